// File: rtl/status_led_pkg.sv
// Shared types and sizing helpers for the status LED block.
// Pure declarations: no latency, no flow control.
package status_led_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    SHOW = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // One LED is the indicator, so each page carries num_leds-1 code bits.
  function automatic int calc_npages(input int code_w, input int num_leds);
    return ceil_div(code_w, num_leds - 1);
  endfunction

endpackage

// File: rtl/reset_stretch.sv
// Holds rst_out low for CYCLES clock edges after resetn releases, then stays high.
// Latency CYCLES edges from reset release; no flow control.
module reset_stretch #(
  parameter int CYCLES = 15
) (
  input  logic clk,
  input  logic resetn,
  output logic rst_out
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      rst_out <= 1'b0;
    end else if (!rst_out) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(CYCLES - 1))
        rst_out <= 1'b1;
    end
  end

endmodule

// File: rtl/status_led_ctrl.sv
// Board status: stretched core reset, heartbeat while running, paged display of the first exit code.
// led updates the cycle after the capture edge; outputs are registered-derived, exit is never backpressured.
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int CODE_W        = 32,
  parameter int RST_CYCLES    = 15,
  parameter int HEARTBEAT_DIV = 24,
  parameter int PAGE_DIV      = 26,
  parameter bit AUTO_TRIM     = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                core_resetn,
  input  logic                exit,
  input  logic [CODE_W-1:0]   exitcode,
  output logic [NUM_LEDS-1:0] led,
  output logic                done
);

  localparam int DW     = NUM_LEDS - 1;
  localparam int NPAGES = calc_npages(CODE_W, NUM_LEDS);
  localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int PADW   = NPAGES * DW;

  state_t                   state_q;
  state_t                   state;
  logic [PADW-1:0]          code_q;
  logic [PADW-1:0]          code_in;
  logic [PW-1:0]            page;
  logic [PW-1:0]            last_page;
  logic [PW-1:0]            nz_page;
  logic [PW-1:0]            capture_last;
  logic [PAGE_DIV-1:0]      page_tmr;
  logic                     blank;
  logic [HEARTBEAT_DIV-1:0] hb;
  logic [DW-1:0]            digit;

  reset_stretch #(.CYCLES(RST_CYCLES)) u_reset_stretch (
    .clk     (clk),
    .resetn  (resetn),
    .rst_out (core_resetn)
  );

  // HOLD is exactly the stretched-reset window; state_q only records whether a code was taken.
  always_comb begin
    state = state_q;
    if (!core_resetn)
      state = HOLD;
    else if (state_q != SHOW)
      state = RUN;
  end

  assign code_in = PADW'(exitcode);

  always_comb begin
    nz_page = '0;
    for (int p = 0; p < NPAGES; p++) begin
      if (|code_in[p*DW +: DW])
        nz_page = PW'(p);
    end
  end

  assign capture_last = AUTO_TRIM ? nz_page : PW'(NPAGES - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= HOLD;
      code_q    <= '0;
      page      <= '0;
      last_page <= '0;
      page_tmr  <= '0;
      blank     <= 1'b0;
      hb        <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          hb <= hb + 1'b1;
          if (exit) begin
            code_q    <= code_in;
            page      <= '0;
            page_tmr  <= '0;
            blank     <= 1'b0;
            done      <= 1'b1;
            last_page <= capture_last;
            state_q   <= SHOW;
          end
        end
        SHOW: begin
          page_tmr <= page_tmr + 1'b1;
          if (&page_tmr) begin
            if (blank) begin
              blank <= 1'b0;
              page  <= '0;
            end else if (page == last_page) begin
              blank <= 1'b1;
            end else begin
              page <= page + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Shift rather than part-select so a padded last page reads zeros instead of out of range.
  assign digit = DW'(code_q >> (page * DW));

  always_comb begin
    led = '0;
    case (state)
      RUN:     led[0] = hb[HEARTBEAT_DIV-1];
      SHOW:    if (!blank) led = {digit, 1'b1};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Randomized bench for status_led_ctrl: two instances (trimmed and untrimmed paging) against a slot-based model.
module tb_status_led_ctrl;

  localparam int NL  = 4;
  localparam int CW  = 8;
  localparam int DW  = NL - 1;
  localparam int NP  = 3;
  localparam int RST = 15;
  localparam int HB  = 3;
  localparam int PD  = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          exit = 1'b0;
  logic [CW-1:0] exitcode = '0;
  logic          crn_a, crn_b, done_a, done_b;
  logic [NL-1:0] led_a, led_b;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 hold, 1 run, 2 show; times counted in clock edges.
  int m_phase = 0;
  int m_edges = 0;
  int m_run_t = 0;
  int m_show_t = 0;
  int m_code = 0;

  always #5 clk = ~clk;

  status_led_ctrl #(
    .NUM_LEDS(NL), .CODE_W(CW), .RST_CYCLES(RST),
    .HEARTBEAT_DIV(HB), .PAGE_DIV(PD), .AUTO_TRIM(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .core_resetn(crn_a),
    .exit(exit), .exitcode(exitcode), .led(led_a), .done(done_a)
  );

  status_led_ctrl #(
    .NUM_LEDS(NL), .CODE_W(CW), .RST_CYCLES(RST),
    .HEARTBEAT_DIV(HB), .PAGE_DIV(PD), .AUTO_TRIM(1'b0)
  ) dut_nt (
    .clk(clk), .resetn(resetn), .core_resetn(crn_b),
    .exit(exit), .exitcode(exitcode), .led(led_b), .done(done_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int page_bits(input int code, input int p);
    return (code >> (p * DW)) & ((1 << DW) - 1);
  endfunction

  function automatic int exp_led(input bit trim);
    int last, slot;
    if (m_phase == 0) return 0;
    if (m_phase == 1) return (m_run_t >> (HB - 1)) & 1;
    last = NP - 1;
    if (trim) begin
      last = 0;
      for (int p = 0; p < NP; p++)
        if (page_bits(m_code, p) != 0) last = p;
    end
    slot = (m_show_t >> PD) % (last + 2);
    if (slot == last + 1) return 0;
    return (page_bits(m_code, slot) << 1) | 1;
  endfunction

  task automatic compare_all();
    chk("core_resetn_a", int'(crn_a), int'(m_phase != 0));
    chk("core_resetn_b", int'(crn_b), int'(m_phase != 0));
    chk("done_a", int'(done_a), int'(m_phase == 2));
    chk("done_b", int'(done_b), int'(m_phase == 2));
    chk("led_trim", int'(led_a), exp_led(1'b1));
    chk("led_notrim", int'(led_b), exp_led(1'b0));
  endtask

  task automatic model_step(input bit x, input int c);
    case (m_phase)
      0: begin
        m_edges++;
        if (m_edges == RST) m_phase = 1;
      end
      1: begin
        m_run_t++;
        if (x) begin
          m_code = c;
          m_phase = 2;
          m_show_t = 0;
        end
      end
      default: m_show_t++;
    endcase
  endtask

  // Called just after a negedge: apply inputs, take one edge, check at the next negedge.
  task automatic cycle(input bit x, input logic [CW-1:0] c);
    exit = x;
    exitcode = c;
    @(posedge clk);
    model_step(x, int'(c));
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges, checks outputs drop immediately, then releases between edges.
  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    m_phase = 0; m_edges = 0; m_run_t = 0; m_show_t = 0; m_code = 0;
    compare_all();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compare_all();
    end
    #2 resetn = 1'b1;
  endtask

  logic [CW-1:0] codes [6];

  initial begin
    #1;
    compare_all();
    codes[0] = 8'h45;
    codes[1] = 8'h05;
    codes[2] = 8'h00;
    codes[3] = 8'h80;
    codes[4] = 8'($urandom);
    codes[5] = 8'($urandom);
    @(negedge clk);
    for (int it = 0; it < 6; it++) begin
      int run_len, lvl;
      do_reset();
      for (int k = 0; k < RST; k++)
        cycle(1'($urandom), 8'($urandom));
      run_len = $urandom_range(3, 20);
      for (int k = 0; k < run_len; k++)
        cycle(1'b0, 8'($urandom));
      cycle(1'b1, codes[it]);
      lvl = $urandom_range(0, 3);
      for (int k = 0; k < 40; k++) begin
        if (k < lvl) cycle(1'b1, codes[it]);
        else if (k % 7 == 3) cycle(1'b1, 8'hFF);
        else cycle(1'($urandom), 8'($urandom));
      end
    end
    do_reset();
    for (int k = 0; k < RST + 2; k++)
      cycle(1'b0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/status_led_ctrl.md
Name: status_led_ctrl

Overview:
Board-level status block between the core and the board LEDs. It is a parametrised successor to the fixed 4-LED exit display.
- Generates a stretched reset for the core.
- Shows a heartbeat on led[0] while the core runs.
- Captures the core's exit code on the first `exit` and shows it on NUM_LEDS LEDs. Codes wider than the LEDs are paged in time, with an optional trim of leading-zero pages and a blank separator slot.

Parameters:
- NUM_LEDS, 4: LED count, minimum 2. led[0] is the indicator; led[NUM_LEDS-1:1] is the data digit. DW = NUM_LEDS-1.
- CODE_W, 32: exit code width.
- RST_CYCLES, 15: number of clk edges core_resetn stays low after resetn releases. Minimum 1.
- HEARTBEAT_DIV, 24: heartbeat counter width. led[0] toggles every 2^(HEARTBEAT_DIV-1) cycles.
- PAGE_DIV, 26: each page (and the blank slot) is shown for 2^PAGE_DIV cycles.
- AUTO_TRIM, 1: 1 = cycle only pages 0..last nonzero page; 0 = cycle all NPAGES.

Ports:
- clk, in, 1: system clock.
- resetn, in, 1: asynchronous active-low reset.
- core_resetn, out, 1: stretched active-low reset to the core. Registered.
- exit, in, 1: core exit flag. Level or pulse.
- exitcode, in, CODE_W: core exit code. Valid while exit=1.
- led, out, NUM_LEDS: LED drive, active-high.
- done, out, 1: high once a code has been captured.

Behaviour:
- Reset is asynchronous and active-low. While resetn=0:
  - state=HOLD; core_resetn=0; done=0; led=0.
  - All counters = 0; code_q = 0; page = 0.
  - Reset asserted mid-operation aborts everything immediately, including a captured code.
- Derived constants: NPAGES = ceil(CODE_W/DW). The last page is zero-padded in its upper bits.
- HOLD state:
  - rst_cnt increments each edge.
  - On the edge where rst_cnt = RST_CYCLES-1: core_resetn<=1, state<=RUN.
  - core_resetn is therefore low for exactly RST_CYCLES edges after resetn rises.
  - exit is ignored in HOLD. led=0.
- RUN state:
  - hb counter (HEARTBEAT_DIV bits) free-runs.
  - led[0] = hb MSB; led[NUM_LEDS-1:1] = 0.
  - On an edge with exit=1: code_q<=exitcode, page<=0, page_tmr<=0, blank<=0, done<=1, state<=SHOW.
  - At the same edge: last_page <= index of the highest page of exitcode with any bit set (0 if exitcode=0), when AUTO_TRIM=1; otherwise NPAGES-1.
- SHOW state (terminal until reset):
  - exit and exitcode are ignored; the first exit wins.
  - page_tmr increments each cycle. On the edge where it wraps (2^PAGE_DIV cycles):
    - If blank=1: blank<=0, page<=0.
    - Else if page = last_page: blank<=1.
    - Else: page<=page+1.
  - Display:
    - Not blank: led[0]=1, led[NUM_LEDS-1:1] = code_q bits [page*DW +: DW], zero-padded.
    - Blank: led = 0.
  - Single-page case (last_page=0): the sequence is page0, blank, page0, and so on.
- Output timing: led is driven combinationally from registers only; there is no combinational path from exit or exitcode. led shows page 0 in the cycle after the capture edge.
- core_resetn stays 1 in RUN and SHOW. The core is not re-reset on exit.
- Width rules:
  - page is $clog2(NPAGES) bits, minimum 1.
  - The page index multiply is constant-folded via a case or shift. It must not index out of range on a padded last page.

Decomposition:
- Package status_led_pkg holds:
  - state enum {HOLD, RUN, SHOW};
  - a function ceil_div;
  - a function calc_npages(CODE_W, NUM_LEDS).
- Sub-module reset_stretch(clk, resetn, rst_out) with parameter CYCLES holds the HOLD counter and core_resetn register. It is reusable by other top levels.
- Paging and display logic stay in status_led_ctrl.

Test Plan:
All scenarios use NUM_LEDS=4, CODE_W=8 (DW=3, NPAGES=3), RST_CYCLES=15, HEARTBEAT_DIV=3, PAGE_DIV=2, AUTO_TRIM=1 unless stated.
- Reset release: resetn 0->1 -> core_resetn=0 for 15 edges, 1 from the 15th edge. led=0 throughout HOLD. exit=1 in HOLD is not captured (done stays 0).
- Heartbeat: RUN with exit=0 -> led[0] toggles every 4 cycles; led[3:1]=000; done=0.
- Capture 0x45, AUTO_TRIM=1 -> repeating sequence, 4 cycles per slot: led=4'b1011 (page0=101), 4'b0001 (page1=000), 4'b0011 (page2=01), then 4'b0000 (blank), then back to 4'b1011. done=1.
- Capture 0x05, AUTO_TRIM=1 -> sequence 4'b1011, 4'b0000, repeating. With AUTO_TRIM=0 -> 4'b1011, 4'b0001, 4'b0001, 4'b0000.
- Second exit: after capturing 0x45, assert exit with 0xFF -> display unchanged; done stays 1.
- Reset mid-SHOW: pull resetn low asynchronously (between edges) -> led=0, done=0, core_resetn=0 immediately. After release, the full 15-cycle HOLD sequence repeats.
